// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared pipeline definitions. Holds the EX-stage operand mux select encodings
// used by both the hazard scoreboard and the EX mux. It also holds the
// countdown-to-select decode shared by every scoreboard entry.
// -----------------------------------------------------------------------------
package mips_pkg;

    // EX operand mux selects
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,  // operand comes from the register file
        FWD_MEMWB   = 2'b01,  // bypass from the MEM/WB register
        FWD_EXMEM   = 2'b10   // bypass from the EX/MEM register
    } fwd_sel_t;

    // A countdown at or above this value means the result is not yet on any
    // bypass path when the consumer reaches EX.
    localparam logic [31:0] CNT_NOT_READY = 32'd4;

    // Countdown value seen at ID -> where the consumer picks the value up in EX.
    // 3: the producer sits in EX/MEM next cycle; 2: in MEM/WB; <=1: regfile.
    function automatic fwd_sel_t fwd_classify(input logic [31:0] cnt);
        if (cnt == 32'd3) begin
            return FWD_EXMEM;
        end else if (cnt == 32'd2) begin
            return FWD_MEMWB;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// Countdown for one architectural register. It loads when a new producer
// issues and drains by one per cycle otherwise. It decodes the count into a
// ready flag and a forward select for a consumer in ID.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load_i         a producer of this register issues this cycle
//   load_val_i     countdown start value (producer latency + 2)
//   cnt_o          current countdown (pre-update)
//   sel_o          forward select for a consumer issuing this cycle
//   ready_o        a consumer issuing this cycle can be bypassed
// -----------------------------------------------------------------------------
module sb_entry
    import mips_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output fwd_sel_t         sel_o,
    output logic             ready_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;                 // a new producer overrides the drain
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: the counter is pipeline state and must clear on reset; a stale count would stall the first instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign sel_o   = fwd_classify(32'(cnt_q));
    assign ready_o = 32'(cnt_q) < CNT_NOT_READY;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks in-flight register writes with a per-register countdown. Decides at ID
// whether the instruction can issue (RAW-not-ready and WAW-reordering stalls).
// Produces registered EX forward selects for the issued instruction.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   id_valid, id_flush       ID holds an instruction / kill it this cycle
//   id_rs, id_rt             source registers; id_use_rs/id_use_rt: actually read
//   id_we, id_rd, id_lat     destination write enable, address, producer latency
//   stall, issue             combinational hold request / instruction leaves ID
//   ex_valid                 registered: EX holds an issued instruction
//   forwardA, forwardB       registered EX mux selects for rs / rt
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_flush,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_we,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [LAT_W-1:0]  id_lat,
    output logic              stall,
    output logic              issue,
    output logic              ex_valid,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_LAT + 3);

    logic [CNT_W-1:0] cnt_arr [NREG];
    fwd_sel_t         sel_arr [NREG];
    logic             rdy_arr [NREG];

    logic [CNT_W-1:0] load_val;
    logic             load_en;
    fwd_sel_t         rs_sel, rt_sel;
    logic             rs_ok, rt_ok, raw, waw, live;

    logic             ex_valid_q, ex_valid_d;
    fwd_sel_t         fwd_a_q, fwd_a_d;
    fwd_sel_t         fwd_b_q, fwd_b_d;

    // Latency 0 is treated as a single-cycle ALU producer.
    always_comb begin
        load_val = ((id_lat == '0) ? CNT_W'(1) : CNT_W'(id_lat)) + CNT_W'(2);
    end

    // Register 0 never has a pending write.
    assign cnt_arr[0] = '0;
    assign sel_arr[0] = FWD_REGFILE;
    assign rdy_arr[0] = 1'b1;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .load_i     (load_en && (id_rd == ADDR_W'(r))),
            .load_val_i (load_val),
            .cnt_o      (cnt_arr[r]),
            .sel_o      (sel_arr[r]),
            .ready_o    (rdy_arr[r])
        );
    end

    // Sources see pre-update counts, so an instruction that reads and writes
    // the same register is matched against the older producer.
    always_comb begin
        rs_sel  = id_use_rs ? sel_arr[id_rs] : FWD_REGFILE;
        rt_sel  = id_use_rt ? sel_arr[id_rt] : FWD_REGFILE;
        rs_ok   = !id_use_rs || rdy_arr[id_rs];
        rt_ok   = !id_use_rt || rdy_arr[id_rt];
        raw     = !(rs_ok && rt_ok);
        // An older, slower write still due after ours would land last.
        waw     = id_we && (id_rd != '0) && (cnt_arr[id_rd] > load_val);
        // A flushed instruction neither stalls nor loads the scoreboard.
        live    = id_valid && !id_flush;
        stall   = live && (raw || waw);
        issue   = live && !stall;
        load_en = issue && id_we && (id_rd != '0);
    end

    // Anything that does not issue becomes a bubble with register-file selects.
    always_comb begin
        ex_valid_d = issue;
        fwd_a_d    = issue ? rs_sel : FWD_REGFILE;
        fwd_b_d    = issue ? rt_sel : FWD_REGFILE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            fwd_a_q    <= FWD_REGFILE;
            fwd_b_q    <= FWD_REGFILE;
        end else begin
            ex_valid_q <= ex_valid_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign forwardA = fwd_a_q;
    assign forwardB = fwd_b_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// The driver applies ID-stage instructions one cycle at a time. A reference
// model keeps, per register, the absolute cycle at which its latest write is
// fully retired. The model gives expected stall/issue for the cycle and the
// registered outputs for the next cycle. The registered expectations are
// queued and a separate monitor compares them once the DUT presents them.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import mips_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int MAX_LAT = 4;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int NREG    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_flush, id_use_rs, id_use_rt, id_we;
    logic [ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic [LAT_W-1:0]  id_lat;
    logic              stall, issue, ex_valid;
    logic [1:0]        forwardA, forwardB;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .ADDR_W  (ADDR_W),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_flush  (id_flush),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_we     (id_we),
        .id_rd     (id_rd),
        .id_lat    (id_lat),
        .stall     (stall),
        .issue     (issue),
        .ex_valid  (ex_valid),
        .forwardA  (forwardA),
        .forwardB  (forwardB)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic       ev;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t exp_q[$];

    // Cycle at which a register's pending write no longer matters (count 0).
    int due[NREG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles of waiting left on register r as seen at cycle now.
    function automatic int remaining(input int r, input int now);
        if (r == 0) return 0;
        return (due[r] > now) ? due[r] - now : 0;
    endfunction

    function automatic logic [1:0] expect_sel(input int c);
        if (c == 3) return FWD_EXMEM;
        if (c == 2) return FWD_MEMWB;
        return FWD_REGFILE;
    endfunction

    // Monitor: compare queued registered outputs once their cycle has come.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ex_valid", 32'(ex_valid), 32'(e.ev));
            check("forwardA", 32'(forwardA), 32'(e.fa));
            check("forwardB", 32'(forwardB), 32'(e.fb));
        end
    end

    // Apply one cycle of ID inputs, check the combinational outputs, queue the
    // registered ones and advance the model.
    task automatic drive(input logic v, input logic f,
                         input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [ADDR_W-1:0] rd, input int lat,
                         output logic issued);
        int   now, l_eff, ca, cb;
        logic raw, waw, es;
        exp_t e;
        @(posedge clk);
        #1;
        id_valid  = v;
        id_flush  = f;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_we     = we;
        id_rd     = rd;
        id_lat    = LAT_W'(lat);
        #1;
        now    = cyc;
        l_eff  = (lat < 1) ? 1 : lat;
        ca     = urs ? remaining(int'(rs), now) : 0;
        cb     = urt ? remaining(int'(rt), now) : 0;
        raw    = (ca >= 4) || (cb >= 4);
        waw    = we && (rd != 0) && (remaining(int'(rd), now) > l_eff + 2);
        es     = v && !f && (raw || waw);
        issued = v && !f && !es;
        check("stall", 32'(stall), 32'(es));
        check("issue", 32'(issue), 32'(issued));
        e.tag = now + 1;
        e.ev  = issued;
        e.fa  = issued ? expect_sel(ca) : FWD_REGFILE;
        e.fb  = issued ? expect_sel(cb) : FWD_REGFILE;
        exp_q.push_back(e);
        if (issued && we && rd != 0) due[rd] = now + l_eff + 3;
    endtask

    // Hold an instruction in ID until it issues; report the stall cycles.
    task automatic send(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [ADDR_W-1:0] rd, input int lat, output int stalls);
        logic ok;
        stalls = 0;
        ok     = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            drive(1'b1, 1'b0, rs, rt, urs, urt, we, rd, lat, ok);
            if (!ok) stalls++;
        end
        check("issue_within_bound", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        logic ok;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1, ok);
    endtask

    // One-cycle reset pulse in the middle of traffic.
    task automatic pulse_reset();
        exp_t e;
        idle(1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        foreach (due[i]) due[i] = 0;
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_forwardA", 32'(forwardA), 32'(FWD_REGFILE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        e.tag = cyc + 1;
        e.ev  = 1'b0;
        e.fa  = FWD_REGFILE;
        e.fb  = FWD_REGFILE;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        logic ok;
        logic v, f, urs, urt, we;
        logic [ADDR_W-1:0] rs, rt, rd;
        int   lat;

        foreach (due[i]) due[i] = 0;
        reset     = 1'b0;
        id_valid  = 1'b0;
        id_flush  = 1'b0;
        id_rs     = '0;
        id_rt     = '0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_we     = 1'b0;
        id_rd     = '0;
        id_lat    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ex_valid", 32'(ex_valid), 32'd0);
        check("reset_forwardA", 32'(forwardA), 32'(FWD_REGFILE));
        check("reset_forwardB", 32'(forwardB), 32'(FWD_REGFILE));
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_issue", 32'(issue), 32'd0);
        reset = 1'b1;

        // ALU chain on r3: EX/MEM, then MEM/WB, then register file.
        send(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1, s);
        send(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1, s);
        check("alu_stalls", 32'(s), 32'd0);
        send(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1, s);
        check("alu_adjacent_fwdA", 32'(forwardA), 32'(FWD_EXMEM));
        check("alu_adjacent_fwdB", 32'(forwardB), 32'(FWD_EXMEM));
        send(5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd9, 1, s);
        check("alu_second_fwdA", 32'(forwardA), 32'(FWD_MEMWB));
        idle(1);
        check("alu_third_fwdB", 32'(forwardB), 32'(FWD_REGFILE));
        check("alu_third_valid", 32'(ex_valid), 32'd1);

        // Load-use on r5: one stall, bubble, then EX/MEM bypass.
        idle(8);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2, s);
        send(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1, s);
        check("lu_stalls", 32'(s), 32'd1);
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_fwdA", 32'(forwardA), 32'(FWD_REGFILE));
        idle(1);
        check("lu_fwdA", 32'(forwardA), 32'(FWD_EXMEM));
        check("lu_valid", 32'(ex_valid), 32'd1);

        // WAW on r6: the mul loads 6; the add (needs <=3) waits while it reads 6, 5, 4.
        idle(8);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 4, s);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1, s);
        check("waw_stalls", 32'(s), 32'd3);

        // r0 writes never create hazards; unused operands are ignored.
        idle(8);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 4, s);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 4, s);
        send(5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1, s);
        check("r0_stalls", 32'(s), 32'd0);
        idle(1);
        check("r0_fwdA", 32'(forwardA), 32'(FWD_REGFILE));
        check("r0_fwdB", 32'(forwardB), 32'(FWD_REGFILE));
        check("r0_valid", 32'(ex_valid), 32'd1);

        // Flush beats stall; the flushed write to r10 never loads; r9 keeps draining.
        idle(8);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 4, s);
        drive(1'b1, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1, ok);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_issue", 32'(issue), 32'd0);
        send(5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1, s);
        check("flush_no_load_stalls", 32'(s), 32'd0);
        send(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1, s);
        check("flush_drain_stalls", 32'(s), 32'd1);

        // Reset while a load is in flight discards it.
        idle(8);
        send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2, s);
        pulse_reset();
        send(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1, s);
        check("rst_reader_stalls", 32'(s), 32'd0);
        idle(1);
        check("rst_reader_fwdA", 32'(forwardA), 32'(FWD_REGFILE));
        check("rst_reader_valid", 32'(ex_valid), 32'd1);

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(9) < 8);
            f   = ($urandom_range(9) == 0);
            rs  = ADDR_W'($urandom_range(7));
            rt  = ADDR_W'($urandom_range(7));
            rd  = ADDR_W'($urandom_range(7));
            urs = 1'($urandom_range(1));
            urt = 1'($urandom_range(1));
            we  = 1'($urandom_range(1));
            lat = $urandom_range(MAX_LAT);
            drive(v, f, rs, rt, urs, urt, we, rd, lat, ok);
        end

        idle(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
